vga_scan_controller: RTL and testbench
======================================

# vga_scan_controller

Parametrised successor to the fixed 640x480 VGA controller. Generates HS/VS/BLANK from configurable porch/sync/active timing, drives a linear frame-buffer read address with optional integer pixel replication (1x/2x/4x), and realigns sync, blank and returned pixel data for a configurable frame-buffer read latency. Sits between the pixel-clock frame buffer and the DAC/pin outputs.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync, back porch (pixel clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync, back porch (lines)
- HS_POL / VS_POL, 0 / 0, active level of oHS / oVS
- SCALE_SHIFT, 0, replication factor 2^SCALE_SHIFT in both axes (0..2)
- RD_LAT, 1, frame-buffer read latency in clocks (1..4)
- ADDR_W, 19, address width; DATA_W, 24, pixel width (8:8:8 RGB at 24)
- vga_clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- rgb_data_raw  in  DATA_W  frame-buffer data, RD_LAT clocks after ADDR
- ADDR  out  ADDR_W  frame-buffer read address (registered)
- oHS / oVS  out  1  syncs, aligned with pixel outputs
- oBLANK_n  out  1  high during visible pixels, aligned
- r_data / g_data / b_data  out  DATA_W/3 each  pixel colour, zero when blanked
- frame_start  out  1  one-clock pulse with the first visible pixel of a frame (aligned)

## Operation
- h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, likewise V. Order per axis: active, FP, sync, BP; count 0 = first visible pixel/line.
- h_cnt wraps to 0 after H_TOTAL-1 and increments v_cnt; v_cnt wraps to 0 after V_TOTAL-1 with h wrap.
- Slot t = counter state in cycle t. active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- Address: row_base register; ADDR = row_base + (h_cnt>>SCALE_SHIFT) when active, else 0. At the h-wrap of a visible line whose low SCALE_SHIFT bits of v_cnt are all 1, row_base += H_ACTIVE>>SCALE_SHIFT; at frame wrap row_base = 0. Sums truncate to ADDR_W.
- Sync: raw HS asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); raw VS for v_cnt in the analogous range; output level per HS_POL/VS_POL.
- Alignment pipeline: active, HS, VS, frame-start flags delayed RD_LAT+1 stages; rgb_data_raw captured exactly when its slot's flags reach the last stage.
- Pixel output = captured data split MSB-first into r/g/b when aligned blank_n=1, else all zero.

## Timing
- Slot t: ADDR valid in cycle t; data sampled at end of cycle t+RD_LAT; oHS/oVS/oBLANK_n/rgb/frame_start for slot t valid in cycle t+RD_LAT+1.
- During reset: counters 0, row_base 0, ADDR 0, oBLANK_n 0, oHS = ~HS_POL, oVS = ~VS_POL, rgb 0, frame_start 0, all pipeline stages cleared to blank/inactive.
- First clock after reset release is slot (0,0); frame_start pulses at cycle RD_LAT+1.
- Reset mid-frame: immediate return to all reset values; no partial-frame state retained.
- Frame wrap and line wrap in the same cycle: frame wrap wins (row_base = 0).

## Configuration
- VGA_SCAN_TEST_PATTERN_EN defined: adds input pattern_sel (1 bit). When 1, rgb_data_raw is ignored and the visible area shows 8 vertical colour bars (bar = h_cnt*8/H_ACTIVE; colour bits {R,G,B} = ~bar[2:0], each bit 0 or all-ones), same latency and alignment. ADDR unchanged.
- Not defined: no pattern_sel port, no pattern logic; data path is frame buffer only.

## Structure
- Package vga_scan_pkg: timing-derivation functions (H_TOTAL, V_TOTAL, sync start/end), default 640x480 constants, colour-bar lookup.
- One sub-module: vga_scan_timing (counters, raw HS/VS/active, line/frame wrap strobes). Address, alignment pipeline and output mux stay in the top.

## Test plan
- Reset then free-run at 640x480 defaults -> oHS period 800 clocks, low 96; oVS period 420000 clocks, low 1600; 307200 blank_n-high cycles per frame.
- Small timing (H 8/2/2/2, V 4/1/1/1, RD_LAT 2), memory model returning ADDR as data -> each visible output pixel equals its slot address, ADDR 0..31 sequential, output 3 clocks after ADDR.
- SCALE_SHIFT 1 with small timing -> ADDR per frame 0,0,1,1,2,2,3,3 on lines 0 and 1, 4,4,..,7,7 on lines 2 and 3; row_base returns to 0 at frame wrap.
- Assert reset mid-line 2 for 3 clocks -> all outputs at reset values immediately; after release frame_start 3 clocks later (RD_LAT 2), ADDR restarts at 0.
- Blanking with nonzero rgb_data_raw (0xFFFFFF) -> r/g/b exactly 0 whenever oBLANK_n is 0.
- With VGA_SCAN_TEST_PATTERN_EN, pattern_sel 1, defaults -> pixels 0..79 white (FF,FF,FF), 80..159 0xFFFF00, 560..639 black.

Source files
------------

// File: rtl/vga_scan_pkg.sv
// Shared timing math, 640x480 defaults and colour-bar lookup for the VGA scan controller.
// VGA_SCAN_TEST_PATTERN_EN widens the alignment flags to carry the colour-bar index.
package vga_scan_pkg;

   localparam int CNT_W = 16;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   function automatic int axis_total(input int act, input int fp, input int sy, input int bp);
      return act + fp + sy + bp;
   endfunction

   function automatic int sync_start(input int act, input int fp);
      return act + fp;
   endfunction

   function automatic int sync_end(input int act, input int fp, input int sy);
      return act + fp + sy;
   endfunction

   // Eight equal bars across the line; bar 0 is white, bar 7 black.
   function automatic logic [2:0] bar_bits(input int h, input int h_active);
      int bar;
      bar = (h * 8) / h_active;
      return ~bar[2:0];
   endfunction

   typedef struct packed {
      logic       active;
      logic       hs;
      logic       vs;
      logic       fs;
`ifdef VGA_SCAN_TEST_PATTERN_EN
      logic [2:0] bar;
`endif
   } scan_flags_t;

endpackage

// File: rtl/vga_scan_timing.sv
// Horizontal/vertical scan counters with raw sync, visible-area flags and wrap strobes.
module vga_scan_timing
   import vga_scan_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] h_cnt_q,
   output logic [CNT_W-1:0] v_cnt_q,
   output logic [CNT_W-1:0] h_cnt_d,
   output logic             active,
   output logic             active_nxt,
   output logic             hs_raw,
   output logic             vs_raw,
   output logic             line_wrap,
   output logic             frame_wrap
);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
   localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_SS   = CNT_W'(sync_start(H_ACTIVE, H_FP));
   localparam logic [CNT_W-1:0] H_SE   = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
   localparam logic [CNT_W-1:0] V_SS   = CNT_W'(sync_start(V_ACTIVE, V_FP));
   localparam logic [CNT_W-1:0] V_SE   = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

   logic [CNT_W-1:0] v_cnt_d;

   always_comb begin
      line_wrap  = (h_cnt_q == H_LAST);
      frame_wrap = line_wrap && (v_cnt_q == V_LAST);
      h_cnt_d    = line_wrap ? '0 : h_cnt_q + 1'b1;
      v_cnt_d    = v_cnt_q;
      if (line_wrap)
         v_cnt_d = frame_wrap ? '0 : v_cnt_q + 1'b1;
      active     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      active_nxt = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
      hs_raw     = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
      vs_raw     = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

endmodule

// File: rtl/vga_scan_controller.sv
// Parametrised VGA scan controller: frame-buffer addressing with pixel replication and
// latency-matched sync/blank/data outputs. VGA_SCAN_TEST_PATTERN_EN adds pattern_sel colour bars.
module vga_scan_controller
   import vga_scan_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_FP        = DEF_H_FP,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BP        = DEF_H_BP,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int V_FP        = DEF_V_FP,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BP        = DEF_V_BP,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0,
   parameter int SCALE_SHIFT = 0,
   parameter int RD_LAT      = 1,
   parameter int ADDR_W      = 19,
   parameter int DATA_W      = 24
) (
   input  logic                vga_clk,
   input  logic                reset,
   input  logic [DATA_W-1:0]   rgb_data_raw,
`ifdef VGA_SCAN_TEST_PATTERN_EN
   input  logic                pattern_sel,
`endif
   output logic [ADDR_W-1:0]   ADDR,
   output logic                oHS,
   output logic                oVS,
   output logic                oBLANK_n,
   output logic [DATA_W/3-1:0] r_data,
   output logic [DATA_W/3-1:0] g_data,
   output logic [DATA_W/3-1:0] b_data,
   output logic                frame_start
);

   localparam int               CW       = DATA_W / 3;
   localparam logic [CNT_W-1:0] V_MASK   = CNT_W'((1 << SCALE_SHIFT) - 1);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

   logic [CNT_W-1:0] h_cnt_q, v_cnt_q, h_cnt_d;
   logic             active, active_nxt, hs_raw, vs_raw, line_wrap, frame_wrap;

   vga_scan_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk(vga_clk), .rst(reset),
      .h_cnt_q(h_cnt_q), .v_cnt_q(v_cnt_q), .h_cnt_d(h_cnt_d),
      .active(active), .active_nxt(active_nxt), .hs_raw(hs_raw), .vs_raw(vs_raw),
      .line_wrap(line_wrap), .frame_wrap(frame_wrap)
   );

   logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
   logic [DATA_W-1:0] pix_q, pix_d, src_data;
   scan_flags_t       pipe_q [0:RD_LAT];
   scan_flags_t       pipe_d [0:RD_LAT];

   // ADDR is registered from next-slot values so it is valid in the same cycle as its slot.
   always_comb begin
      row_base_d = row_base_q;
      if (frame_wrap)
         row_base_d = '0;
      else if (line_wrap && (v_cnt_q < V_ACT) && ((v_cnt_q & V_MASK) == V_MASK))
         row_base_d = row_base_q + ROW_STEP;
      addr_d = active_nxt ? row_base_d + ADDR_W'(h_cnt_d >> SCALE_SHIFT) : '0;
   end

   always_comb begin
      pipe_d[0]        = '0;
      pipe_d[0].active = active;
      pipe_d[0].hs     = hs_raw;
      pipe_d[0].vs     = vs_raw;
      pipe_d[0].fs     = (h_cnt_q == '0) && (v_cnt_q == '0);
`ifdef VGA_SCAN_TEST_PATTERN_EN
      pipe_d[0].bar    = bar_bits(int'(h_cnt_q), H_ACTIVE);
`endif
      for (int i = 1; i <= RD_LAT; i++)
         pipe_d[i] = pipe_q[i-1];
   end

   // Data is captured on the edge where its slot's flags move into the output stage.
   always_comb begin
      src_data = rgb_data_raw;
`ifdef VGA_SCAN_TEST_PATTERN_EN
      if (pattern_sel)
         src_data = DATA_W'({{CW{pipe_q[RD_LAT-1].bar[2]}},
                             {CW{pipe_q[RD_LAT-1].bar[1]}},
                             {CW{pipe_q[RD_LAT-1].bar[0]}}});
`endif
      pix_d = pipe_q[RD_LAT-1].active ? src_data : '0;
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         row_base_q <= '0;
         addr_q     <= '0;
         pix_q      <= '0;
         for (int i = 0; i <= RD_LAT; i++)
            pipe_q[i] <= '0;
      end else begin
         row_base_q <= row_base_d;
         addr_q     <= addr_d;
         pix_q      <= pix_d;
         pipe_q     <= pipe_d;
      end
   end

   assign ADDR        = addr_q;
   assign oHS         = pipe_q[RD_LAT].hs ? HS_POL : ~HS_POL;
   assign oVS         = pipe_q[RD_LAT].vs ? VS_POL : ~VS_POL;
   assign oBLANK_n    = pipe_q[RD_LAT].active;
   assign frame_start = pipe_q[RD_LAT].fs;
   assign r_data      = pix_q[DATA_W-1 -: CW];
   assign g_data      = pix_q[DATA_W-1-CW -: CW];
   assign b_data      = pix_q[DATA_W-1-2*CW -: CW];

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench for vga_scan_controller: default 640x480 instance plus two small-timing instances.
module tb_vga_scan_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // default 640x480, RD_LAT 1
   logic [23:0] dd_data;
   logic [18:0] d_addr;
   logic        d_hs, d_vs, d_bn, d_fs;
   logic [7:0]  d_r, d_g, d_b;
`ifdef VGA_SCAN_TEST_PATTERN_EN
   logic        psel;
`endif

   // small timing, RD_LAT 2, memory returns address
   logic [23:0] m1, m2;
   logic [18:0] s_addr;
   logic        s_hs, s_vs, s_bn, s_fs;
   logic [7:0]  s_r, s_g, s_b;

   // small timing, 2x replication, constant white data
   logic [23:0] xs_data;
   logic [18:0] x_addr;
   logic        x_hs, x_vs, x_bn, x_fs;
   logic [7:0]  x_r, x_g, x_b;

   vga_scan_controller dut_d (
      .vga_clk(clk), .reset(rst), .rgb_data_raw(dd_data),
`ifdef VGA_SCAN_TEST_PATTERN_EN
      .pattern_sel(psel),
`endif
      .ADDR(d_addr), .oHS(d_hs), .oVS(d_vs), .oBLANK_n(d_bn),
      .r_data(d_r), .g_data(d_g), .b_data(d_b), .frame_start(d_fs)
   );

   vga_scan_controller #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .RD_LAT(2)
   ) dut_s (
      .vga_clk(clk), .reset(rst), .rgb_data_raw(m2),
`ifdef VGA_SCAN_TEST_PATTERN_EN
      .pattern_sel(1'b0),
`endif
      .ADDR(s_addr), .oHS(s_hs), .oVS(s_vs), .oBLANK_n(s_bn),
      .r_data(s_r), .g_data(s_g), .b_data(s_b), .frame_start(s_fs)
   );

   vga_scan_controller #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .RD_LAT(2), .SCALE_SHIFT(1)
   ) dut_x (
      .vga_clk(clk), .reset(rst), .rgb_data_raw(xs_data),
`ifdef VGA_SCAN_TEST_PATTERN_EN
      .pattern_sel(1'b0),
`endif
      .ADDR(x_addr), .oHS(x_hs), .oVS(x_vs), .oBLANK_n(x_bn),
      .r_data(x_r), .g_data(x_g), .b_data(x_b), .frame_start(x_fs)
   );

   // frame-buffer model with a two-clock read latency
   always @(posedge clk) begin
      m1 <= {5'd0, s_addr};
      m2 <= m1;
   end

   task automatic apply_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({d_addr, d_bn, d_hs, d_vs, d_fs, d_r, d_g, d_b} !== {19'd0, 4'b0110, 24'd0}) begin
         n_bad++;
         $display("FAIL reset_default: got addr=%0d bn/hs/vs/fs=%b%b%b%b rgb=%h, want 0 0110 0",
                  d_addr, d_bn, d_hs, d_vs, d_fs, {d_r, d_g, d_b});
      end
      n_cmp++;
      if ({s_addr, s_bn, s_hs, s_vs, s_fs, s_r, s_g, s_b} !== {19'd0, 4'b0110, 24'd0}) begin
         n_bad++;
         $display("FAIL reset_small: got addr=%0d bn/hs/vs/fs=%b%b%b%b rgb=%h, want 0 0110 0",
                  s_addr, s_bn, s_hs, s_vs, s_fs, {s_r, s_g, s_b});
      end
      n_cmp++;
      if ({x_addr, x_bn, x_hs, x_vs, x_fs, x_r, x_g, x_b} !== {19'd0, 4'b0110, 24'd0}) begin
         n_bad++;
         $display("FAIL reset_scale: got addr=%0d bn/hs/vs/fs=%b%b%b%b rgb=%h, want 0 0110 0",
                  x_addr, x_bn, x_hs, x_vs, x_fs, {x_r, x_g, x_b});
      end
   endtask

   // H_TOTAL 14, V_TOTAL 7; expected values from slot arithmetic over two frames.
   task automatic test_small_timing();
      int h, v, s;
      logic act;
      logic [23:0] ea;
      logic [3:0]  ef;
      logic [23:0] er;
      apply_reset();
      for (int c = 0; c < 2 * 98 + 3; c++) begin
         h = c % 14;
         v = (c / 14) % 7;
         ea = (h < 8 && v < 4) ? 24'(v * 8 + h) : 24'd0;
         n_cmp++;
         if (s_addr !== ea[18:0]) begin
            n_bad++;
            $display("FAIL small_addr c=%0d: got %0d want %0d", c, s_addr, ea);
         end
         s = c - 3;
         if (s < 0) begin
            ef = 4'b0110;
            er = 24'd0;
         end else begin
            h = s % 14;
            v = (s / 14) % 7;
            act = (h < 8 && v < 4);
            ef = {act, !(h >= 10 && h < 12), !(v == 5), (h == 0 && v == 0)};
            er = act ? 24'(v * 8 + h) : 24'd0;
         end
         n_cmp++;
         if ({s_bn, s_hs, s_vs, s_fs} !== ef || {s_r, s_g, s_b} !== er) begin
            n_bad++;
            $display("FAIL small_out c=%0d: got bn/hs/vs/fs=%b%b%b%b rgb=%h want %b rgb=%h",
                     c, s_bn, s_hs, s_vs, s_fs, {s_r, s_g, s_b}, ef, er);
         end
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_scale();
      int h, v;
      logic [23:0] ea;
      apply_reset();
      for (int c = 0; c < 2 * 98 + 3; c++) begin
         h = c % 14;
         v = (c / 14) % 7;
         ea = (h < 8 && v < 4) ? 24'((v >> 1) * 4 + (h >> 1)) : 24'd0;
         n_cmp++;
         if (x_addr !== ea[18:0]) begin
            n_bad++;
            $display("FAIL scale_addr c=%0d: got %0d want %0d", c, x_addr, ea);
         end
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_blanking();
      int h, v, s;
      logic eb;
      apply_reset();
      for (int c = 0; c < 98 + 3; c++) begin
         s = c - 3;
         h = (s < 0) ? 0 : s % 14;
         v = (s < 0) ? 0 : (s / 14) % 7;
         eb = (s >= 0) && (h < 8) && (v < 4);
         n_cmp++;
         if (x_bn !== eb || {x_r, x_g, x_b} !== (eb ? 24'hFFFFFF : 24'd0)) begin
            n_bad++;
            $display("FAIL blank c=%0d: got bn=%b rgb=%h want bn=%b", c, x_bn, {x_r, x_g, x_b}, eb);
         end
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      repeat (31) begin
         @(negedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if ({s_addr, s_bn, s_hs, s_vs, s_fs, s_r, s_g, s_b} !== {19'd0, 4'b0110, 24'd0}) begin
            n_bad++;
            $display("FAIL midreset_hold k=%0d: got addr=%0d bn/hs/vs/fs=%b%b%b%b rgb=%h",
                     k, s_addr, s_bn, s_hs, s_vs, s_fs, {s_r, s_g, s_b});
         end
         if (k < 3) begin
            @(negedge clk);
            #1;
         end
      end
      rst = 1'b0;
      #1;
      for (int c = 0; c < 6; c++) begin
         n_cmp++;
         if (s_addr !== 19'(c) || s_fs !== (c == 3) || s_bn !== (c >= 3) ||
             {s_r, s_g, s_b} !== ((c >= 3) ? 24'(c - 3) : 24'd0)) begin
            n_bad++;
            $display("FAIL midreset_restart c=%0d: got addr=%0d fs=%b bn=%b rgb=%h",
                     c, s_addr, s_fs, s_bn, {s_r, s_g, s_b});
         end
         @(negedge clk);
         #1;
      end
   endtask

   // Three lines at 640x480: HS falls at 658 (656 + RD_LAT + 1), period 800, low 96.
   task automatic test_default_timing();
      int fall0, fall1, rise0, bn_cnt, vs_low;
      logic prev_hs;
      fall0 = -1; fall1 = -1; rise0 = -1; bn_cnt = 0; vs_low = 0;
      dd_data = 24'h123456;
      apply_reset();
      prev_hs = d_hs;
      for (int c = 0; c < 2400; c++) begin
         if (prev_hs && !d_hs) begin
            if (fall0 < 0) fall0 = c;
            else if (fall1 < 0) fall1 = c;
         end
         if (!prev_hs && d_hs && rise0 < 0) rise0 = c;
         prev_hs = d_hs;
         if (d_bn) bn_cnt++;
         if (!d_vs) vs_low++;
         n_cmp++;
         if (d_fs !== (c == 2) || {d_r, d_g, d_b} !== (d_bn ? 24'h123456 : 24'd0)) begin
            n_bad++;
            $display("FAIL default_pix c=%0d: got fs=%b bn=%b rgb=%h", c, d_fs, d_bn, {d_r, d_g, d_b});
         end
         if (c == 639 || c == 640 || c == 800 || c == 1439) begin
            n_cmp++;
            if (d_addr !== ((c == 639) ? 19'd639 : (c == 640) ? 19'd0 :
                            (c == 800) ? 19'd640 : 19'd1279)) begin
               n_bad++;
               $display("FAIL default_addr c=%0d: got %0d", c, d_addr);
            end
         end
         @(negedge clk);
         #1;
      end
      n_cmp++;
      if (fall0 !== 658) begin
         n_bad++;
         $display("FAIL hs_first_fall: got %0d want 658", fall0);
      end
      n_cmp++;
      if (fall1 - fall0 !== 800) begin
         n_bad++;
         $display("FAIL hs_period: got %0d want 800", fall1 - fall0);
      end
      n_cmp++;
      if (rise0 - fall0 !== 96) begin
         n_bad++;
         $display("FAIL hs_low: got %0d want 96", rise0 - fall0);
      end
      n_cmp++;
      if (bn_cnt !== 1920) begin
         n_bad++;
         $display("FAIL blank_count: got %0d want 1920", bn_cnt);
      end
      n_cmp++;
      if (vs_low !== 0) begin
         n_bad++;
         $display("FAIL vs_early: got %0d low cycles want 0", vs_low);
      end
   endtask

`ifdef VGA_SCAN_TEST_PATTERN_EN
   task automatic test_pattern();
      int          hp [6] = '{0, 79, 80, 159, 560, 639};
      logic [23:0] ep [6] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00, 24'h000000, 24'h000000};
      int          k;
      psel = 1'b1;
      dd_data = 24'h123456;
      apply_reset();
      k = 0;
      for (int c = 0; c < 660 && k < 6; c++) begin
         if (c == hp[k] + 2) begin
            n_cmp++;
            if ({d_r, d_g, d_b} !== ep[k] || d_bn !== 1'b1) begin
               n_bad++;
               $display("FAIL pattern h=%0d: got rgb=%h bn=%b want %h", hp[k], {d_r, d_g, d_b}, d_bn, ep[k]);
            end
            k++;
         end
         @(negedge clk);
         #1;
      end
      psel = 1'b0;
   endtask
`endif

   initial begin
      dd_data = 24'h123456;
      xs_data = 24'hFFFFFF;
`ifdef VGA_SCAN_TEST_PATTERN_EN
      psel = 1'b0;
`endif
      @(negedge clk);
      test_reset();
      test_small_timing();
      test_scale();
      test_blanking();
      test_mid_reset();
      test_default_timing();
`ifdef VGA_SCAN_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
